// File: rtl/simple_axi_pkg.sv
// Shared types and constants for the two-port AXI read arbiter.
// SIMPLE_AXI_RD_ARB_4K_CHECK_EN adds the ERR state and the 4 KB crossing helper.
package simple_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
`ifdef SIMPLE_AXI_RD_ARB_4K_CHECK_EN
    , ST_ERR = 2'd3
`endif
  } state_e;

  localparam logic [1:0]  RESP_OKAY       = 2'b00;
  localparam logic [1:0]  RESP_SLVERR     = 2'b10;
  localparam int unsigned AXI_4K_BOUNDARY = 4096;

`ifdef SIMPLE_AXI_RD_ARB_4K_CHECK_EN
  // End address of a 4-byte-per-beat burst, relative to its 4 KB page.
  function automatic logic crosses_4k(input logic [11:0] addr_lo, input logic [7:0] len);
    logic [13:0] end_addr;
    end_addr = {2'b00, addr_lo} + (({6'b0, len} + 14'd1) << 2);
    return end_addr > 14'(AXI_4K_BOUNDARY);
  endfunction
`endif

endpackage

// File: rtl/simple_axi_if.sv
// AXI read-address/read-data bundle; burst attributes are fixed here.
interface simple_axi_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [3:0]    arcache;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  // Full-width INCR bursts, normal non-cacheable bufferable.
  assign arsize  = 3'($clog2(DW / 8));
  assign arburst = 2'b01;
  assign arcache = 4'b0011;
endinterface

// File: rtl/simple_axi_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last accepted requester.
module simple_axi_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_q, last_d;

  always_comb begin
    gnt_idx = 1'b0;
    unique case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;
      default: gnt_idx = 1'b0;
    endcase
    gnt    = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
    last_d = accept ? gnt_idx : last_q;
  end

  // Reset to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/simple_axi_rd_arb.sv
// Two-requester AXI read arbiter with one outstanding burst and rlast/length checking.
// Define SIMPLE_AXI_RD_ARB_4K_CHECK_EN to answer 4 KB-crossing commands locally with SLVERR.
module simple_axi_rd_arb
  import simple_axi_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        arst,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] req0_addr,
  input  logic [7:0]                  req0_len,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] req1_addr,
  input  logic [7:0]                  req1_len,
  output logic                        rd0_valid,
  input  logic                        rd0_ready,
  output logic [C_AXI_DATA_WIDTH-1:0] rd0_data,
  output logic [1:0]                  rd0_resp,
  output logic                        rd0_last,
  output logic                        rd1_valid,
  input  logic                        rd1_ready,
  output logic [C_AXI_DATA_WIDTH-1:0] rd1_data,
  output logic [1:0]                  rd1_resp,
  output logic                        rd1_last,
  output logic [C_AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]                  axi_arlen,
  output logic [2:0]                  axi_arsize,
  output logic [1:0]                  axi_arburst,
  output logic [3:0]                  axi_arcache,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rlast,
  input  logic                        axi_rvalid,
  output logic                        axi_rready
);

  simple_axi_if #(.AW(C_AXI_ADDR_WIDTH), .DW(C_AXI_DATA_WIDTH)) m_axi ();

  state_e                      state_q, state_d;
  logic                        owner_q, owner_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                  len_q, len_d;
  logic [7:0]                  cnt_q, cnt_d;

  logic [1:0]                  gnt;
  logic                        gnt_idx;
  logic                        in_idle;
  logic                        accept;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_sel;
  logic [7:0]                  len_sel;
  logic                        own_ready;
  logic                        ar_valid;
  logic                        r_ready;
  logic                        beat_valid;
  logic [C_AXI_DATA_WIDTH-1:0] beat_data;
  logic [1:0]                  beat_resp;
  logic                        beat_last;

  // Ready is masked by reset so nothing handshakes while arst is high.
  assign in_idle    = (state_q == ST_IDLE) && !arst;
  assign accept     = in_idle && (req0_valid || req1_valid);
  assign req0_ready = in_idle && gnt[0];
  assign req1_ready = in_idle && gnt[1];
  assign addr_sel   = gnt_idx ? req1_addr : req0_addr;
  assign len_sel    = gnt_idx ? req1_len : req0_len;
  assign own_ready  = owner_q ? rd1_ready : rd0_ready;

  simple_axi_rr_arb2 u_rr_arb (
    .clk     (aclk),
    .rst     (arst),
    .req     ({req1_valid, req0_valid}),
    .accept  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    beat_valid = 1'b0;
    beat_data  = '0;
    beat_resp  = RESP_OKAY;
    beat_last  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = gnt_idx;
          addr_d  = addr_sel;
          len_d   = len_sel;
          cnt_d   = 8'd0;
`ifdef SIMPLE_AXI_RD_ARB_4K_CHECK_EN
          state_d = crosses_4k(addr_sel[11:0], len_sel) ? ST_ERR : ST_AR;
`else
          state_d = ST_AR;
`endif
        end
      end

      ST_AR: begin
        ar_valid = 1'b1;
        if (m_axi.arready) state_d = ST_R;
      end

      // A beat whose rlast disagrees with the expected length is flagged SLVERR.
      ST_R: begin
        beat_valid = m_axi.rvalid;
        r_ready    = own_ready;
        beat_data  = m_axi.rdata;
        beat_last  = m_axi.rlast;
        beat_resp  = (m_axi.rlast != (cnt_q == len_q)) ? RESP_SLVERR : m_axi.rresp;
        if (m_axi.rvalid && own_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (m_axi.rlast) state_d = ST_IDLE;
        end
      end

`ifdef SIMPLE_AXI_RD_ARB_4K_CHECK_EN
      ST_ERR: begin
        beat_valid = 1'b1;
        beat_resp  = RESP_SLVERR;
        beat_last  = (cnt_q == len_q);
        if (own_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_axi.arvalid = ar_valid;
  assign m_axi.araddr  = ar_valid ? addr_q : '0;
  assign m_axi.arlen   = ar_valid ? len_q : 8'd0;
  assign m_axi.arready = axi_arready;
  assign m_axi.rdata   = axi_rdata;
  assign m_axi.rresp   = axi_rresp;
  assign m_axi.rlast   = axi_rlast;
  assign m_axi.rvalid  = axi_rvalid;
  assign m_axi.rready  = r_ready;

  assign axi_araddr  = m_axi.araddr;
  assign axi_arlen   = m_axi.arlen;
  assign axi_arsize  = m_axi.arsize;
  assign axi_arburst = m_axi.arburst;
  assign axi_arcache = m_axi.arcache;
  assign axi_arvalid = m_axi.arvalid;
  assign axi_rready  = m_axi.rready;

  // Only the owning port ever sees a beat.
  assign rd0_valid = beat_valid && !owner_q;
  assign rd0_data  = owner_q ? '0 : beat_data;
  assign rd0_resp  = owner_q ? RESP_OKAY : beat_resp;
  assign rd0_last  = beat_last && !owner_q;
  assign rd1_valid = beat_valid && owner_q;
  assign rd1_data  = owner_q ? beat_data : '0;
  assign rd1_resp  = owner_q ? beat_resp : RESP_OKAY;
  assign rd1_last  = beat_last && owner_q;

endmodule

// File: tb/tb_simple_axi_rd_arb.sv
// Scoreboard bench for simple_axi_rd_arb with a small AXI slave model.
// Honours SIMPLE_AXI_RD_ARB_4K_CHECK_EN for the 4 KB crossing case.
module tb_simple_axi_rd_arb;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        owner;
  } ar_t;

  logic        aclk, arst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_addr, req1_addr;
  logic [7:0]  req0_len, req1_len;
  logic        rd0_valid, rd0_ready, rd0_last, rd1_valid, rd1_ready, rd1_last;
  logic [31:0] rd0_data, rd1_data;
  logic [1:0]  rd0_resp, rd1_resp;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [3:0]  axi_arcache;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready;

  int          num_checks = 0;
  int          num_fail   = 0;
  beat_t       exp0[$];
  beat_t       exp1[$];
  ar_t         exp_ar[$];
  int          exp_grant[$];
  int          beats0 = 0;
  int          grants_seen = 0;
  logic [31:0] model_base;
  logic [31:0] slv_base;
  int          slv_last_at = -1;
  bit          bp_en = 0;
  bit          in_r = 0;
  bit          chk_idle = 0;
  logic        cur_owner = 0;
  beat_t       mb;
  ar_t         ma;
  int          mg;

  simple_axi_rd_arb #(.C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32)) dut (
    .aclk(aclk), .arst(arst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
    .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_data(rd0_data), .rd0_resp(rd0_resp),
    .rd0_last(rd0_last),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_data(rd1_data), .rd1_resp(rd1_resp),
    .rd1_last(rd1_last),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arcache(axi_arcache),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got no end of test, required end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // rd0_ready alternates every cycle while backpressure is enabled, otherwise stays high.
  initial begin
    rd0_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      rd0_ready = bp_en ? ~rd0_ready : 1'b1;
    end
  end

  // Slave: one-cycle arready delay, then beats slv_base+i with rlast at slv_last_at (or arlen).
  initial begin : slave_model
    int          last_idx;
    logic [31:0] base;
    bit          aborted;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0;
    forever begin
      @(negedge aclk);
      if (!arst && axi_arvalid && !axi_arready) begin
        @(posedge aclk);
        #1 axi_arready = 1'b1;
      end else if (!arst && axi_arvalid && axi_arready) begin
        last_idx = (slv_last_at < 0) ? int'(axi_arlen) : slv_last_at;
        base     = slv_base;
        slv_base = slv_base + 32'h100;
        aborted  = 1'b0;
        @(posedge aclk);
        #1 axi_arready = 1'b0;
        for (int i = 0; i <= last_idx && !aborted; i++) begin
          axi_rvalid = 1'b1;
          axi_rdata  = base + 32'(i);
          axi_rlast  = (i == last_idx);
          do @(negedge aclk); while (!axi_rready && !arst);
          if (arst) aborted = 1'b1;
          else begin
            @(posedge aclk);
            #1;
          end
        end
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge aclk) begin
    if (arst) begin
      in_r     = 1'b0;
      chk_idle = 1'b0;
    end else begin
      if (chk_idle) begin
        checkOutput("idle_after_last_rready", axi_rready, 1'b0);
        chk_idle = 1'b0;
      end
      if (in_r && axi_rvalid) begin
        checkOutput("nonowner_rd_valid", cur_owner ? rd0_valid : rd1_valid, 1'b0);
        checkOutput("rready_mirror", axi_rready, cur_owner ? rd1_ready : rd0_ready);
      end
      if (rd0_valid && rd0_ready) begin
        beats0++;
        if (exp0.size() == 0) checkOutput("rd0_unexpected_beat", rd0_valid, 1'b0);
        else begin
          mb = exp0.pop_front();
          checkOutput("rd0_data", rd0_data, mb.data);
          checkOutput("rd0_resp", rd0_resp, mb.resp);
          checkOutput("rd0_last", rd0_last, mb.last);
        end
      end
      if (rd1_valid && rd1_ready) begin
        if (exp1.size() == 0) checkOutput("rd1_unexpected_beat", rd1_valid, 1'b0);
        else begin
          mb = exp1.pop_front();
          checkOutput("rd1_data", rd1_data, mb.data);
          checkOutput("rd1_resp", rd1_resp, mb.resp);
          checkOutput("rd1_last", rd1_last, mb.last);
        end
      end
      if (axi_rvalid && axi_rready && axi_rlast) begin
        in_r     = 1'b0;
        chk_idle = 1'b1;
      end
      if (axi_arvalid && axi_arready) begin
        if (exp_ar.size() == 0) checkOutput("ar_unexpected", axi_arvalid, 1'b0);
        else begin
          ma = exp_ar.pop_front();
          checkOutput("araddr", axi_araddr, ma.addr);
          checkOutput("arlen", axi_arlen, ma.len);
          cur_owner = ma.owner;
          in_r      = 1'b1;
        end
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        grants_seen++;
        if (exp_grant.size() == 0) checkOutput("grant_unexpected", 1'b1, 1'b0);
        else begin
          mg = exp_grant.pop_front();
          checkOutput("grant_order", req1_ready ? 1 : 0, mg);
        end
      end
    end
  end

  task automatic pushExpect(input int port, input logic [31:0] addr, input logic [7:0] len,
                            input int last_at, input int n_exp, input bit is_err);
    int    lidx;
    beat_t b;
    ar_t   a;
    lidx = (last_at < 0) ? int'(len) : last_at;
    exp_grant.push_back(port);
    if (!is_err) begin
      a.addr = addr; a.len = len; a.owner = (port != 0);
      exp_ar.push_back(a);
    end
    for (int i = 0; i < n_exp; i++) begin
      if (is_err) begin
        b.data = '0; b.resp = 2'b10; b.last = (i == int'(len));
      end else begin
        b.data = model_base + 32'(i);
        b.last = (i == lidx);
        b.resp = ((i == lidx) != (i == int'(len))) ? 2'b10 : 2'b00;
      end
      if (port == 0) exp0.push_back(b);
      else           exp1.push_back(b);
    end
    if (!is_err) model_base = model_base + 32'h100;
  endtask

  task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [7:0] len,
                               input int last_at, input int n_exp, input bit is_err);
    int   n;
    logic rdy;
    pushExpect(port, addr, len, last_at, n_exp, is_err);
    slv_last_at = last_at;
    @(posedge aclk);
    #1;
    if (port == 0) begin req0_valid = 1'b1; req0_addr = addr; req0_len = len; end
    else           begin req1_valid = 1'b1; req1_addr = addr; req1_len = len; end
    n = 0;
    do begin
      @(negedge aclk);
      n++;
      rdy = (port == 0) ? req0_ready : req1_ready;
    end while (!rdy && n < 50);
    checkOutput("req_accept", rdy, 1'b1);
    @(posedge aclk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge aclk);
    checkOutput("arvalid_after_accept", axi_arvalid, !is_err);
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || exp_ar.size() != 0 || in_r) && n < 400) begin
      @(negedge aclk);
      n++;
    end
    checkOutput(tag, (n < 400), 1'b1);
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    int n;
    int b0;
    int g0;
    arst = 1'b1;
    req0_valid = 1'b1; req0_addr = 32'h100; req0_len = 8'd3;
    req1_valid = 1'b0; req1_addr = '0;      req1_len = 8'd0;
    rd1_ready  = 1'b1;
    slv_base   = 32'hA0;
    model_base = 32'hA0;
    $display("[TB] start");

    #12;
    checkOutput("rst_req0_ready", req0_ready, 1'b0);
    checkOutput("rst_arvalid", axi_arvalid, 1'b0);
    checkOutput("rst_rready", axi_rready, 1'b0);
    checkOutput("rst_araddr", axi_araddr, 32'h0);
    checkOutput("rst_arlen", axi_arlen, 8'h0);
    checkOutput("rst_rd0_valid", rd0_valid, 1'b0);
    checkOutput("rst_rd0_outs", {rd0_data, rd0_resp, rd0_last}, 35'h0);
    checkOutput("rst_rd1_outs", {rd1_valid, rd1_data, rd1_resp, rd1_last}, 36'h0);
    checkOutput("arsize_fixed", axi_arsize, 3'd2);
    checkOutput("arburst_fixed", axi_arburst, 2'b01);
    req0_valid = 1'b0;
    @(negedge aclk);
    arst = 1'b0;
    repeat (2) @(negedge aclk);

    $display("[TB] single command");
    applyStimulus(0, 32'h100, 8'd3, -1, 4, 1'b0);
    waitDone("single_done");

    $display("[TB] backpressure");
    bp_en = 1'b1;
    applyStimulus(0, 32'h200, 8'd7, -1, 8, 1'b0);
    waitDone("backpressure_done");
    bp_en = 1'b0;
    repeat (2) @(negedge aclk);

    $display("[TB] early rlast");
    applyStimulus(0, 32'h300, 8'd3, 1, 2, 1'b0);
    waitDone("early_last_done");

    $display("[TB] late rlast");
    applyStimulus(1, 32'h600, 8'd1, 2, 3, 1'b0);
    waitDone("late_last_done");

    $display("[TB] 4 KB crossing command");
`ifdef SIMPLE_AXI_RD_ARB_4K_CHECK_EN
    applyStimulus(0, 32'hFF8, 8'd3, -1, 4, 1'b1);
`else
    applyStimulus(0, 32'hFF8, 8'd3, -1, 4, 1'b0);
`endif
    waitDone("cross4k_done");

    $display("[TB] reset mid-transfer");
    b0 = beats0;
    applyStimulus(0, 32'h400, 8'd7, -1, 2, 1'b0);
    n = 0;
    do begin
      @(posedge aclk);
      n++;
    end while (beats0 < b0 + 2 && n < 100);
    checkOutput("reset_two_beats_seen", beats0 - b0, 2);
    #3 arst = 1'b1;
    #1;
    checkOutput("async_rst_arvalid", axi_arvalid, 1'b0);
    checkOutput("async_rst_rready", axi_rready, 1'b0);
    checkOutput("async_rst_rd0_valid", rd0_valid, 1'b0);
    repeat (3) @(negedge aclk);
    arst = 1'b0;
    repeat (3) @(negedge aclk);
    checkOutput("no_beats_after_reset", beats0 - b0, 2);

    $display("[TB] contention after reset");
    slv_last_at = -1;
    for (int k = 0; k < 4; k++)
      pushExpect(k % 2, (k % 2 == 0) ? 32'h200 : 32'h300, 8'd1, -1, 2, 1'b0);
    g0 = grants_seen;
    @(posedge aclk);
    #1;
    req0_valid = 1'b1; req0_addr = 32'h200; req0_len = 8'd1;
    req1_valid = 1'b1; req1_addr = 32'h300; req1_len = 8'd1;
    n = 0;
    do begin
      @(posedge aclk);
      n++;
    end while (grants_seen < g0 + 4 && n < 400);
    checkOutput("contention_grants", grants_seen - g0, 4);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitDone("contention_done");

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
